serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//   Bit-serial add/subtract controller. Owns exactly one 1-bit full-adder cell
//   (a, b, c -> h, l) and one carry flop. It sequences W-bit operands through
//   the cell LSB-first, one bit per clock, and returns an aligned W-bit result.
//   It is the low-area arithmetic engine for narrow datapaths in the design.
// PARAMETERS
//   W        8   operand/result width in bits; legal range W >= 1
// PORTS
//   clk      in   1  rising-edge clock
//   rst      in   1  asynchronous, active-high reset
//   start    in   1  request; accepted on a rising edge of clk while ready=1
//   sub      in   1  0: a+b, 1: a-b; sampled with start
//   a        in   W  operand A; sampled with start
//   b        in   W  operand B; sampled with start
//   ready    out  1  combinational: state != RUN
//   busy     out  1  combinational: state == RUN
//   done     out  1  one-cycle pulse; result is valid in this cycle
//   sum      out  W  result, LSB-first shift register
//   cout     out  1  final carry (for sub: 1 = no borrow, i.e. a >= b unsigned)
//   overflow out  1  signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//   - Reset, asynchronous, applies immediately and at any time. It sets
//     state=IDLE, sum=0, cout=0, overflow=0, done=0, carry=0, bit counter=0.
//     Therefore ready=1 and busy=0. Reset during RUN aborts: no done, no partial result kept.
//   - FSM states: IDLE, RUN, DONE.
//       IDLE : start=1 -> RUN (accept).
//       RUN  : cnt==W-1 -> DONE. start is ignored and has no effect.
//       DONE : start=1 -> RUN (back-to-back accept). Otherwise -> IDLE.
//   - Accept edge:
//       opA <= a.
//       opB <= sub ? ~b : b.
//       carry <= sub.
//       cnt <= 0.
//       done <= 0.
//   - Each RUN edge (bit i = cnt):
//       cell inputs are a=opA[0], b=opB[0], c=carry.
//       carry <= h.
//       sum <= {l, sum[W-1:1]}.
//       opA and opB shift right by 1.
//       cnt <= cnt+1.
//     When i==W-1, also latch overflow <= carry XOR h (carry = carry into the MSB)
//     and cout <= h.
//   - Latency: accept on edge k; the bits are processed on edges k+1..k+W; done=1
//     in the cycle after edge k+W (the DONE state). done is exactly 1 cycle wide,
//     including back-to-back operation.
//   - sum, cout and overflow hold their values after DONE until the next accept.
//     sum changes during RUN, so the bench must compare it only when done=1 or
//     in IDLE afterwards.
//   - Arithmetic is modulo 2^W. cout/overflow use the usual two's-complement meaning.
//   - W=1: RUN lasts one edge. overflow = carry-in XOR carry-out of that single bit.
//   - cnt width is $clog2(W)+1 bits; it never wraps inside RUN.
// TESTING
//   1. W=8: a=0x35, b=0x4A, sub=0 -> sum=0x7F, cout=0, overflow=0; done exactly
//      8 edges after the accept edge, 1 cycle wide.
//   2. a=0xFF, b=0x01, sub=0 -> sum=0x00, cout=1, overflow=0.
//      a=0x7F, b=0x01 -> sum=0x80, cout=0, overflow=1.
//   3. sub=1: a=0x10, b=0x20 -> sum=0xF0, cout=0, ovf=0.
//      a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
//   4. start pulsed with a=0x01 at RUN bit 3 of a 0x35+0x4A op -> ignored; the
//      result is still 0x7F. ready=0 throughout RUN.
//   5. start held high from DONE with new operands 0x0F+0x01 -> RUN entered directly,
//      the second done arrives 9 cycles after the first, sum=0x10, no IDLE cycle.
//   6. rst asserted mid-RUN (between edges) -> outputs 0 immediately, no done.
//      The next op 0x02+0x03 -> 0x05. Also run W=1: 1+1 -> sum=0, cout=1, ovf=1.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract engine: one full-adder cell plus a carry flop.
// The cell is sequenced LSB-first over W-bit operands, one bit per clock.

module serial_adder_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_h,
  output logic o_l
);
  assign o_l = i_a ^ i_b ^ i_c;
  assign o_h = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_adder_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         overflow
);
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [W-1:0]   r_op_a;
  logic [W-1:0]   r_op_b;
  logic [W-1:0]   r_sum;
  logic [W-1:0]   w_sum_shift;
  logic [CW-1:0]  r_cnt;
  logic           r_carry;
  logic           r_cout;
  logic           r_ovf;
  logic           r_done;
  logic           w_h;
  logic           w_l;
  logic           w_last;
  logic           w_accept;

  serial_adder_fa u_fa (
    .i_a (r_op_a[0]),
    .i_b (r_op_b[0]),
    .i_c (r_carry),
    .o_h (w_h),
    .o_l (w_l)
  );

  assign w_last   = (r_cnt == LAST);
  assign w_accept = start && (r_state != S_RUN);

  // New result bits enter at the MSB so the word is aligned after W shifts.
  generate
    if (W == 1) begin : g_sum_w1
      assign w_sum_shift = w_l;
    end else begin : g_sum_wn
      assign w_sum_shift = {w_l, r_sum[W-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is a + ~b + 1: the +1 rides in as the initial carry.
      r_op_a  <= a;
      r_op_b  <= sub ? ~b : b;
      r_carry <= sub;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_carry <= w_h;
      r_sum   <= w_sum_shift;
      r_op_a  <= r_op_a >> 1;
      r_op_b  <= r_op_b >> 1;
      r_cnt   <= r_cnt + CW'(1);
      r_done  <= w_last;
      if (w_last) begin
        r_cout <= w_h;
        r_ovf  <= r_carry ^ w_h;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign ready    = (r_state != S_RUN);
  assign busy     = (r_state == S_RUN);
  assign done     = r_done;
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: stimulus pushes expected results,
// per-instance monitors pop and compare whenever done is seen.

module tb_serial_adder_ctrl;
  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       o;
    int         e;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, sub = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       ready, busy, done, cout, overflow;
  logic [7:0] sum;

  logic       start1 = 1'b0, sub1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       ready1, busy1, done1, cout1, ovf1;
  logic [0:0] sum1;

  int   edge_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb8[$];
  exp_t sb1[$];
  logic prev_done = 1'b0, prev_done1 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  serial_adder_ctrl #(.W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout),
    .overflow(overflow)
  );

  serial_adder_ctrl #(.W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
    .overflow(ovf1)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor for the W=8 instance
  always @(negedge clk) begin
    if (!rst) begin
      check("ready_vs_busy", int'(ready), int'(!busy));
      if (done) begin
        check("done_width", int'(prev_done), 0);
        if (sb8.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb8.pop_front();
          check("sum", int'(sum), int'(e.s));
          check("cout", int'(cout), int'(e.c));
          check("overflow", int'(overflow), int'(e.o));
          check("done_edge", edge_cnt, e.e);
          $display("W8 done: sum=%02h cout=%0b ovf=%0b edge=%0d", sum, cout, overflow, edge_cnt);
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Monitor for the W=1 instance
  always @(negedge clk) begin
    if (!rst) begin
      if (done1) begin
        check("w1_done_width", int'(prev_done1), 0);
        if (sb1.size() == 0) begin
          check("w1_unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb1.pop_front();
          check("w1_sum", int'(sum1), int'(e.s[0]));
          check("w1_cout", int'(cout1), int'(e.c));
          check("w1_overflow", int'(ovf1), int'(e.o));
          check("w1_done_edge", edge_cnt, e.e);
          $display("W1 done: sum=%0b cout=%0b ovf=%0b edge=%0d", sum1, cout1, ovf1, edge_cnt);
        end
      end
      prev_done1 = done1;
    end else begin
      prev_done1 = 1'b0;
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_timeout", 0, 1);
  endtask

  // Issue one W=8 op from a negedge; returns #1 after the accept edge.
  task automatic issue(input logic [7:0] ta, input logic [7:0] tb_, input logic ts,
                       input logic [7:0] es, input logic ec, input logic eo);
    exp_t e;
    @(negedge clk);
    wait_ready();
    a = ta; b = tb_; sub = ts; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.s = es; e.c = ec; e.o = eo; e.e = edge_cnt + 8;
    sb8.push_back(e);
    $display("W8 issue: a=%02h b=%02h sub=%0b exp=%02h/%0b/%0b", ta, tb_, ts, es, ec, eo);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((sb8.size() != 0 || sb1.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", sb8.size() + sb1.size(), 0);
  endtask

  initial begin
    exp_t e1;
    int   n;
    // Reset state
    #1;
    check("rst_ready", int'(ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_sum", int'(sum), 0);
    check("rst_cout_ovf", int'({cout, overflow}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic add / sub vectors
    issue(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    issue(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    issue(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
    issue(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    issue(8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0);

    // start pulsed mid-RUN must be ignored
    issue(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("run_ready", int'(ready), 0);
    a = 8'h01; b = 8'h00; start = 1'b1;
    @(negedge clk);
    check("run_ready2", int'(ready), 0);
    start = 1'b0;

    // Back-to-back: hold start from DONE with new operands
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("b2b_wait_done", int'(done), 1);
    a = 8'h0F; b = 8'h01; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_busy", int'(busy), 1);
    e1.s = 8'h10; e1.c = 1'b0; e1.o = 1'b0; e1.e = edge_cnt + 8;
    sb8.push_back(e1);
    $display("W8 issue: a=0f b=01 sub=0 back-to-back exp=10/0/0");
    @(negedge clk);
    start = 1'b0;
    drain(40);

    // Reset mid-RUN aborts, outputs clear immediately
    issue(8'hAA, 8'h11, 1'b0, 8'hBB, 1'b0, 1'b0);
    void'(sb8.pop_back());
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_sum", int'(sum), 0);
    check("abort_ready", int'(ready), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_cout_ovf", int'({cout, overflow}), 0);
    $display("W8 reset mid-RUN applied");
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue(8'h02, 8'h03, 1'b0, 8'h05, 1'b0, 1'b0);
    drain(40);

    // W=1 instance: 1+1
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; sub1 = 1'b0; start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    e1.s = 8'h00; e1.c = 1'b1; e1.o = 1'b1; e1.e = edge_cnt + 1;
    sb1.push_back(e1);
    $display("W1 issue: a=1 b=1 sub=0 exp=0/1/1");
    drain(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
